// File: rtl/anc_loop_sequencer_if.sv
// Strobe and data bundle between the ANC loop sequencer and the
// audio source, cup simulator and adaptive filter.
interface anc_loop_sequencer_if;
    logic        enable_in;
    logic        amb_valid_in;
    logic [15:0] amb_sample_in;
    logic        amb_ready_out;
    logic        sim_ready_out;
    logic [15:0] sim_ambient_out;
    logic [7:0]  sim_speaker_out;
    logic        sim_done_in;
    logic [15:0] sim_feedback_in;
    logic        filt_valid_out;
    logic [15:0] filt_feedback_out;
    logic        filt_done_in;
    logic [7:0]  filt_speaker_in;
    logic        busy_out;
    logic        timeout_out;
    logic [15:0] overrun_count_out;
    logic [31:0] pass_count_out;

    modport master (
        input  enable_in, amb_valid_in, amb_sample_in,
        input  sim_done_in, sim_feedback_in,
        input  filt_done_in, filt_speaker_in,
        output amb_ready_out, sim_ready_out,
        output sim_ambient_out, sim_speaker_out,
        output filt_valid_out, filt_feedback_out,
        output busy_out, timeout_out,
        output overrun_count_out, pass_count_out
    );

    modport slave (
        output enable_in, amb_valid_in, amb_sample_in,
        output sim_done_in, sim_feedback_in,
        output filt_done_in, filt_speaker_in,
        input  amb_ready_out, sim_ready_out,
        input  sim_ambient_out, sim_speaker_out,
        input  filt_valid_out, filt_feedback_out,
        input  busy_out, timeout_out,
        input  overrun_count_out, pass_count_out
    );
endinterface

// File: rtl/anc_loop_sequencer.sv
// Per-sample scheduler for the closed ANC loop: source -> cup sim -> filter.
// Define ANC_LOOP_STATS_EN to build the overrun and pass counters.
module anc_loop_sequencer #(
    parameter int CYCLES_PER_SAMPLE = 2268,
    parameter int TIMEOUT_CYCLES    = 512
) (
    input logic                  clk_in,
    input logic                  reset_n_in,
    anc_loop_sequencer_if.master bus
);
    localparam int TW = $clog2(CYCLES_PER_SAMPLE);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(CYCLES_PER_SAMPLE - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, FETCH, SIM_GO, SIM_WAIT, FILT_GO, FILT_WAIT
    } state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [15:0]   amb_q, amb_d;
    logic [15:0]   fb_q, fb_d;
    logic [7:0]    spk_q, spk_d;
    logic          to_q, to_d;
    logic          amb_ready_q, sim_ready_q, filt_valid_q, busy_q;
    logic          tick, pass_inc, overrun_inc;

    always_comb begin
        tick        = (tick_q == TICK_LAST);
        tick_d      = tick ? '0 : tick_q + 1'b1;
        overrun_inc = tick && (state_q != IDLE);
    end

    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        amb_d    = amb_q;
        fb_d     = fb_q;
        spk_d    = spk_q;
        to_d     = to_q;
        pass_inc = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (tick && bus.enable_in) state_d = FETCH;
            end
            FETCH: begin
                if (bus.amb_valid_in) begin
                    amb_d   = bus.amb_sample_in;
                    state_d = SIM_GO;
                end
            end
            SIM_GO: begin
                wait_d  = '0;
                state_d = SIM_WAIT;
            end
            SIM_WAIT: begin
                // done beats an expiry landing in the same cycle
                if (bus.sim_done_in) begin
                    fb_d    = bus.sim_feedback_in;
                    state_d = FILT_GO;
                end else if (wait_q == WAIT_LAST) begin
                    to_d    = 1'b1;
                    state_d = IDLE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            FILT_GO: begin
                wait_d  = '0;
                state_d = FILT_WAIT;
            end
            FILT_WAIT: begin
                if (bus.filt_done_in) begin
                    spk_d    = bus.filt_speaker_in;
                    pass_inc = 1'b1;
                    state_d  = IDLE;
                end else if (wait_q == WAIT_LAST) begin
                    to_d    = 1'b1;
                    state_d = IDLE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!reset_n_in) begin
            state_q      <= IDLE;
            tick_q       <= '0;
            wait_q       <= '0;
            amb_q        <= '0;
            fb_q         <= '0;
            spk_q        <= '0;
            to_q         <= 1'b0;
            amb_ready_q  <= 1'b0;
            sim_ready_q  <= 1'b0;
            filt_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            wait_q       <= wait_d;
            amb_q        <= amb_d;
            fb_q         <= fb_d;
            spk_q        <= spk_d;
            to_q         <= to_d;
            amb_ready_q  <= (state_d == FETCH);
            sim_ready_q  <= (state_d == SIM_GO);
            filt_valid_q <= (state_d == FILT_GO);
            busy_q       <= (state_d != IDLE);
        end
    end

    assign bus.amb_ready_out     = amb_ready_q;
    assign bus.sim_ready_out     = sim_ready_q;
    assign bus.sim_ambient_out   = amb_q;
    assign bus.sim_speaker_out   = spk_q;
    assign bus.filt_valid_out    = filt_valid_q;
    assign bus.filt_feedback_out = fb_q;
    assign bus.busy_out          = busy_q;
    assign bus.timeout_out       = to_q;

`ifdef ANC_LOOP_STATS_EN
    logic [15:0] ovr_q, ovr_d;
    logic [31:0] pass_q, pass_d;

    always_comb begin
        ovr_d  = ovr_q;
        pass_d = pass_q;
        if (overrun_inc && (ovr_q != 16'hFFFF)) ovr_d = ovr_q + 1'b1;
        if (pass_inc) pass_d = pass_q + 1'b1;
    end

    always_ff @(posedge clk_in) begin
        if (!reset_n_in) begin
            ovr_q  <= '0;
            pass_q <= '0;
        end else begin
            ovr_q  <= ovr_d;
            pass_q <= pass_d;
        end
    end

    assign bus.overrun_count_out = ovr_q;
    assign bus.pass_count_out    = pass_q;
`else
    logic unused_stats;
    assign unused_stats          = overrun_inc ^ pass_inc;
    assign bus.overrun_count_out = '0;
    assign bus.pass_count_out    = '0;
`endif
endmodule
